// File: rtl/aftab_csr_rmw_unit.sv
// CSR read-modify-write responder: 16 implemented CSRs, Zicsr RW/RS/RC
// (register and immediate forms) via a start/done handshake, plus a
// hardware trap port that loads mepc/mcause/mtval in any state.
module aftab_csr_rmw_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        startCSR,
  input  logic [2:0]  funct3,
  input  logic [11:0] csrAddress,
  input  logic [4:0]  rs1Field,
  input  logic [31:0] rs1Data,
  input  logic        trapWrite,
  input  logic [31:0] trapMepc,
  input  logic [31:0] trapMcause,
  input  logic [31:0] trapMtval,
  output logic        doneCSR,
  output logic        illegalCSR,
  output logic [31:0] rdData,
  output logic [31:0] mstatusOut,
  output logic [31:0] mieOut,
  output logic [31:0] mtvecOut,
  output logic [31:0] mepcOut,
  output logic [31:0] mipOut
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [3:0] IDX_MSTATUS = 4'd0;
  localparam logic [3:0] IDX_MIE     = 4'd3;
  localparam logic [3:0] IDX_MTVEC   = 4'd4;
  localparam logic [3:0] IDX_MEPC    = 4'd5;
  localparam logic [3:0] IDX_MCAUSE  = 4'd6;
  localparam logic [3:0] IDX_MTVAL   = 4'd7;
  localparam logic [3:0] IDX_MIP     = 4'd8;

  state_t      state_q, state_d;
  logic [1:0]  op_q;        // funct3[1:0]: 01 RW, 10 RS, 11 RC, 00 invalid
  logic [3:0]  idx_q;
  logic        addr_ok_q;
  logic [4:0]  rs1f_q;
  logic [31:0] opnd_q;
  logic [31:0] old_q;
  logic        illegal_q;
  logic [31:0] rd_q;
  logic        ill_out_q;
  logic [31:0] csr_q [16];

  logic        ill_now;
  logic        sw_we;
  logic [31:0] new_val;

  // Map a CSR address to its storage slot; bit 4 flags an implemented CSR.
  function automatic logic [4:0] csr_index(input logic [11:0] a);
    case (a)
      12'h300: csr_index = 5'h10;  // mstatus
      12'h302: csr_index = 5'h11;  // medeleg
      12'h303: csr_index = 5'h12;  // mideleg
      12'h304: csr_index = 5'h13;  // mie
      12'h305: csr_index = 5'h14;  // mtvec
      12'h341: csr_index = 5'h15;  // mepc
      12'h342: csr_index = 5'h16;  // mcause
      12'h343: csr_index = 5'h17;  // mtval
      12'h344: csr_index = 5'h18;  // mip
      12'h000: csr_index = 5'h19;  // ustatus
      12'h004: csr_index = 5'h1A;  // uie
      12'h005: csr_index = 5'h1B;  // utvec
      12'h041: csr_index = 5'h1C;  // uepc
      12'h042: csr_index = 5'h1D;  // ucause
      12'h043: csr_index = 5'h1E;  // utval
      12'h044: csr_index = 5'h1F;  // uip
      default: csr_index = 5'h00;
    endcase
  endfunction

  // Read-modify-write combine of the old value with the operand.
  function automatic logic [31:0] rmw(input logic [1:0] op, input logic [31:0] old,
                                      input logic [31:0] opnd);
    case (op)
      2'b01:   rmw = opnd;
      2'b10:   rmw = old | opnd;
      default: rmw = old & ~opnd;
    endcase
  endfunction

  assign ill_now = !addr_ok_q || (op_q == 2'b00);
  // Set/clear with a zero rs1 field is a pure read; RW always writes.
  assign sw_we   = (state_q == S_WRITE) && !illegal_q && ((op_q == 2'b01) || (rs1f_q != 5'd0));
  assign new_val = rmw(op_q, old_q, opnd_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: IDLE -> READ -> (WRITE ->) DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (startCSR) state_d = S_READ;
      S_READ:  state_d = ill_now ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, old-value capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 2'b00;
      idx_q     <= 4'd0;
      addr_ok_q <= 1'b0;
      rs1f_q    <= 5'd0;
      opnd_q    <= 32'd0;
      old_q     <= 32'd0;
      illegal_q <= 1'b0;
      rd_q      <= 32'd0;
      ill_out_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && startCSR) begin
        op_q               <= funct3[1:0];
        {addr_ok_q, idx_q} <= csr_index(csrAddress);
        rs1f_q             <= rs1Field;
        opnd_q             <= funct3[2] ? {27'd0, rs1Field} : rs1Data;
        rd_q               <= 32'd0;
        ill_out_q          <= 1'b0;
      end
      if (state_q == S_READ) begin
        old_q     <= csr_q[idx_q];
        illegal_q <= ill_now;
        if (ill_now) begin
          rd_q      <= 32'd0;
          ill_out_q <= 1'b1;
        end
      end
      if (state_q == S_WRITE) begin
        rd_q      <= old_q;
        ill_out_q <= 1'b0;
      end
    end
  end

  // CSR storage: software commit, then trap update overriding the trap CSRs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) csr_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (sw_we && idx_q == 4'(i)) csr_q[i] <= new_val;
      if (trapWrite) begin
        csr_q[IDX_MEPC]   <= trapMepc;
        csr_q[IDX_MCAUSE] <= trapMcause;
        csr_q[IDX_MTVAL]  <= trapMtval;
      end
    end
  end

  assign doneCSR    = (state_q == S_DONE);
  assign illegalCSR = ill_out_q;
  assign rdData     = rd_q;
  assign mstatusOut = csr_q[IDX_MSTATUS];
  assign mieOut     = csr_q[IDX_MIE];
  assign mtvecOut   = csr_q[IDX_MTVEC];
  assign mepcOut    = csr_q[IDX_MEPC];
  assign mipOut     = csr_q[IDX_MIP];

endmodule

// File: tb/tb_aftab_csr_rmw_unit.sv
// Randomized bench for aftab_csr_rmw_unit against an address-keyed CSR model.
module tb_aftab_csr_rmw_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startCSR;
  logic [2:0]  funct3;
  logic [11:0] csrAddress;
  logic [4:0]  rs1Field;
  logic [31:0] rs1Data;
  logic        trapWrite;
  logic [31:0] trapMepc, trapMcause, trapMtval;
  logic        doneCSR, illegalCSR;
  logic [31:0] rdData, mstatusOut, mieOut, mtvecOut, mepcOut, mipOut;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] m [int];
  int legal_addrs [16] = '{'h300, 'h302, 'h303, 'h304, 'h305, 'h341, 'h342, 'h343,
                           'h344, 'h000, 'h004, 'h005, 'h041, 'h042, 'h043, 'h044};

  aftab_csr_rmw_unit dut (
    .clk(clk), .rst(rst), .startCSR(startCSR), .funct3(funct3),
    .csrAddress(csrAddress), .rs1Field(rs1Field), .rs1Data(rs1Data),
    .trapWrite(trapWrite), .trapMepc(trapMepc), .trapMcause(trapMcause),
    .trapMtval(trapMtval), .doneCSR(doneCSR), .illegalCSR(illegalCSR),
    .rdData(rdData), .mstatusOut(mstatusOut), .mieOut(mieOut),
    .mtvecOut(mtvecOut), .mepcOut(mepcOut), .mipOut(mipOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m.delete();
    foreach (legal_addrs[i]) m[legal_addrs[i]] = 32'd0;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".mstatus"}, mstatusOut, m['h300]);
    check({tag, ".mie"},     mieOut,     m['h304]);
    check({tag, ".mtvec"},   mtvecOut,   m['h305]);
    check({tag, ".mepc"},    mepcOut,    m['h341]);
    check({tag, ".mip"},     mipOut,     m['h344]);
  endtask

  // One Zicsr access. trap: raise trapWrite during the WRITE cycle.
  // hold: keep startCSR high for the whole access (must be ignored).
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1f,
                        input logic [31:0] r1d, input bit trap, input bit hold);
    bit          legal, wr, is_trap_reg;
    logic [31:0] opnd, old, nv, tm, tc, tv;
    int          cnt, exp_lat;
    legal   = m.exists(int'(a)) && (f3[1:0] != 2'b00);
    opnd    = f3[2] ? {27'd0, r1f} : r1d;
    old     = legal ? m[int'(a)] : 32'd0;
    exp_lat = legal ? 3 : 2;
    tm = $urandom; tc = $urandom; tv = $urandom;
    if (!legal) trap = 0;
    if (legal) begin
      wr = (f3[1:0] == 2'b01) || (r1f != 0);
      case (f3[1:0])
        2'b01:   nv = opnd;
        2'b10:   nv = old | opnd;
        default: nv = old & ~opnd;
      endcase
      is_trap_reg = (a == 12'h341) || (a == 12'h342) || (a == 12'h343);
      if (wr && !(trap && is_trap_reg)) m[int'(a)] = nv;
      if (trap) begin
        m['h341] = tm; m['h342] = tc; m['h343] = tv;
      end
    end

    @(negedge clk);
    startCSR = 1; funct3 = f3; csrAddress = a; rs1Field = r1f; rs1Data = r1d;
    @(posedge clk); #1;
    cnt = 1;
    if (!hold) startCSR = 0;
    funct3 = 3'($urandom); csrAddress = 12'($urandom); rs1Field = 5'($urandom); rs1Data = $urandom;
    while (cnt < 10 && !doneCSR) begin
      if (cnt == 2 && trap) begin
        trapWrite = 1; trapMepc = tm; trapMcause = tc; trapMtval = tv;
      end
      @(posedge clk); #1;
      trapWrite = 0;
      cnt++;
    end
    startCSR = 0;
    check("latency", cnt, exp_lat);
    check("illegal", {31'd0, illegalCSR}, {31'd0, !legal});
    check("rdData", rdData, old);
    check_outs("outs");
    @(posedge clk); #1;
    check("done_pulse_end", {31'd0, doneCSR}, 32'd0);
    check("rdData_hold", rdData, old);
  endtask

  initial begin
    int dc;
    rst = 1; startCSR = 0; funct3 = 0; csrAddress = 0; rs1Field = 0; rs1Data = 0;
    trapWrite = 0; trapMepc = 0; trapMcause = 0; trapMtval = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.done", {31'd0, doneCSR}, 32'd0);
    check("rst.illegal", {31'd0, illegalCSR}, 32'd0);
    check("rst.rdData", rdData, 32'd0);
    check_outs("rst");
    @(negedge clk); rst = 0;

    // Directed scenarios
    run_op(3'b001, 12'h305, 5'd3, 32'h8000_0100, 0, 0);
    run_op(3'b001, 12'h304, 5'd1, 32'h0000_0008, 0, 0);
    run_op(3'b010, 12'h304, 5'd5, 32'h0000_0888, 0, 0);
    run_op(3'b111, 12'h304, 5'd8, 32'hFFFF_FFFF, 0, 0);
    check("mie_final", mieOut, 32'h0000_0880);
    run_op(3'b001, 12'h342, 5'd2, 32'h0000_1234, 0, 0);
    run_op(3'b010, 12'h342, 5'd0, 32'hA5A5_A5A5, 0, 0);
    run_op(3'b001, 12'h301, 5'd1, 32'h1, 0, 0);
    run_op(3'b001, 12'hC00, 5'd1, 32'h1, 0, 0);
    run_op(3'b010, 12'h001, 5'd1, 32'h1, 0, 0);
    run_op(3'b100, 12'h300, 5'd1, 32'h1, 0, 0);
    run_op(3'b000, 12'h304, 5'd1, 32'h1, 0, 0);
    run_op(3'b001, 12'h341, 5'd1, 32'h1111_1111, 1, 0);
    run_op(3'b011, 12'h305, 5'd4, 32'h0000_0100, 0, 1);

    // Reset asserted during WRITE of CSRRW mstatus
    @(negedge clk);
    startCSR = 1; funct3 = 3'b001; csrAddress = 12'h300; rs1Field = 5'd1; rs1Data = 32'hDEAD_BEEF;
    @(posedge clk); #1; startCSR = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    model_reset();
    dc = 0;
    repeat (5) begin
      if (doneCSR) dc++;
      @(posedge clk); #1;
    end
    check("rst_mid.done_count", dc, 0);
    check("rst_mid.rdData", rdData, 32'd0);
    check_outs("rst_mid");
    run_op(3'b001, 12'h300, 5'd1, 32'h0000_1888, 0, 0);

    // Randomized accesses
    for (int k = 0; k < 80; k++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  r1f;
      f3  = 3'($urandom);
      a   = ($urandom_range(0, 3) != 0) ? 12'(legal_addrs[$urandom_range(0, 15)]) : 12'($urandom);
      r1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_op(f3, a, r1f, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
